controlador_serie_paralelo: RTL and testbench

CONTROLADOR_SERIE_PARALELO -- requirements
Module: controlador_serie_paralelo

---
 rtl/controlador_serie_paralelo.sv | 162 ++++++++++++++++
 tb/tb_controlador_serie_paralelo.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/controlador_serie_paralelo.sv
// Serial-to-parallel receiver: start bit, 4 data bits (MSB first), optional even
// parity bit, stop bit. Bits are sampled only on tick cycles. The received word is
// presented on q with a valid/ready handshake; error and overrun flags are
// one-cycle registered pulses.
// Optional feature: define PARITY_CHECK_EN to insert and check a parity bit.
module controlador_serie_paralelo (
  input  logic       clk,
  input  logic       clear,
  input  logic       tick,
  input  logic       d,
  input  logic       ready,
  output logic [3:0] q,
  output logic       valid,
  output logic       busy,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun
);

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity,
    StStop
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [3:0] sr_q, sr_d;
  logic [3:0] q_q, q_d;
  logic       valid_q, valid_d;
  logic       busy_q, busy_d;
  logic       frame_err_q, frame_err_d;
  logic       overrun_q, overrun_d;
  logic       complete;

`ifdef PARITY_CHECK_EN
  logic       par_ok_q, par_ok_d;
  logic       parity_err_q, parity_err_d;
`endif

  // Next-state, datapath and output-flag computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    q_d         = q_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    complete    = 1'b0;
`ifdef PARITY_CHECK_EN
    par_ok_d     = par_ok_q;
    parity_err_d = 1'b0;
`endif

    // Consumer handshake; a word completing this cycle may re-set valid below.
    if (valid_q && ready) begin
      valid_d = 1'b0;
    end

    if (tick) begin
      unique case (state_q)
        StIdle: begin
          if (!d) begin
            state_d = StData;
            cnt_d   = 2'd0;
          end
        end
        StData: begin
          sr_d  = {sr_q[2:0], d};
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
`ifdef PARITY_CHECK_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
`ifdef PARITY_CHECK_EN
        StParity: begin
          // Even parity over the four data bits plus the parity bit.
          par_ok_d = ~((^sr_q) ^ d);
          state_d  = StStop;
        end
`endif
        StStop: begin
          state_d = StIdle;
          if (!d) begin
            // A bad stop bit masks any parity mismatch.
            frame_err_d = 1'b1;
`ifdef PARITY_CHECK_EN
          end else if (!par_ok_q) begin
            parity_err_d = 1'b1;
`endif
          end else begin
            complete = 1'b1;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end

    // Deliver the word, or drop it when the previous one is still held.
    if (complete) begin
      if (!valid_q || ready) begin
        q_d     = sr_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end

    busy_d = (state_d != StIdle);
  end

  // State and registered outputs, with synchronous clear taking priority.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q     <= StIdle;
      cnt_q       <= 2'd0;
      sr_q        <= 4'b0000;
      q_q         <= 4'b0000;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef PARITY_CHECK_EN
      par_ok_q     <= 1'b1;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      q_q         <= q_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef PARITY_CHECK_EN
      par_ok_q     <= par_ok_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign q         = q_q;
  assign valid     = valid_q;
  assign busy      = busy_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
`ifdef PARITY_CHECK_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_controlador_serie_paralelo.sv
// Self-checking bench for controlador_serie_paralelo. Expected results come from a
// frame-level model: each frame's outcome is decided from its bits and the
// handshake state, not from cycle-level FSM behaviour.
module tb_controlador_serie_paralelo;

  logic       clk;
  logic       clear;
  logic       tick;
  logic       d;
  logic       ready;
  logic [3:0] q;
  logic       valid;
  logic       busy;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;

  int errors;
  int checks;

  // Reference model state: the word held for the consumer.
  logic [3:0] q_m;
  logic       valid_m;

`ifdef PARITY_CHECK_EN
  localparam bit ParOn = 1'b1;
`else
  localparam bit ParOn = 1'b0;
`endif

  controlador_serie_paralelo dut (
    .clk       (clk),
    .clear     (clear),
    .tick      (tick),
    .d         (d),
    .ready     (ready),
    .q         (q),
    .valid     (valid),
    .busy      (busy),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock cycle with the given inputs; outputs are sampled 1 time unit later.
  task automatic cyc(input logic t, input logic dd, input logic rd);
    tick  = t;
    d     = dd;
    ready = rd;
    @(posedge clk);
    #1;
  endtask

  // Sends one frame; ready is asserted only on the stop-bit tick.
  task automatic send_frame(input logic [3:0] data, input logic bad_par,
                            input logic stop_bit, input int gap, input logic rdy_stop);
    logic bits[$];
    logic exp_fe, exp_pe, exp_ov, good;
    bits.push_back(1'b0);
    for (int i = 3; i >= 0; i--) bits.push_back(data[i]);
    if (ParOn) bits.push_back((^data) ^ bad_par);
    bits.push_back(stop_bit);

    for (int i = 0; i < bits.size(); i++) begin
      if (i == bits.size() - 1) begin
        cyc(1'b1, bits[i], rdy_stop);
      end else begin
        cyc(1'b1, bits[i], 1'b0);
        for (int g = 1; g < gap; g++) cyc(1'b0, 1'($urandom_range(0, 1)), 1'b0);
        checks++;
        if (busy !== 1'b1 || {frame_err, parity_err, overrun} !== 3'b000) begin
          errors++;
          $display("FAIL mid_frame bit%0d: busy=%b flags=%b%b%b required busy=1 flags=000",
                   i, busy, frame_err, parity_err, overrun);
        end
      end
    end

    // Frame-level outcome.
    exp_fe = !stop_bit;
    exp_pe = stop_bit && ParOn && bad_par;
    good   = stop_bit && !exp_pe;
    exp_ov = 1'b0;
    if (good) begin
      if (!valid_m || rdy_stop) begin
        q_m     = data;
        valid_m = 1'b1;
      end else begin
        exp_ov = 1'b1;
      end
    end else if (valid_m && rdy_stop) begin
      valid_m = 1'b0;
    end

    checks++;
    if ({frame_err, parity_err, overrun} !== {exp_fe, exp_pe, exp_ov}) begin
      errors++;
      $display("FAIL frame_flags data=%b: fe/pe/ov=%b%b%b required %b%b%b", data,
               frame_err, parity_err, overrun, exp_fe, exp_pe, exp_ov);
    end
    checks++;
    if (valid !== valid_m || q !== q_m) begin
      errors++;
      $display("FAIL frame_word data=%b: valid=%b q=%b required valid=%b q=%b", data,
               valid, q, valid_m, q_m);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL frame_busy_end: busy=%b required 0", busy);
    end

    cyc(1'b0, 1'b1, 1'b0);
    checks++;
    if ({frame_err, parity_err, overrun} !== 3'b000) begin
      errors++;
      $display("FAIL pulse_width: fe/pe/ov=%b%b%b required 000", frame_err, parity_err,
               overrun);
    end
  endtask

  // One idle cycle with the given ready; checks the handshake effect.
  task automatic handshake(input logic rd, input logic t);
    cyc(t, 1'b1, rd);
    if (valid_m && rd) valid_m = 1'b0;
    checks++;
    if (valid !== valid_m || q !== q_m || busy !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL handshake rd=%b: valid=%b q=%b busy=%b ov=%b required %b %b 0 0", rd,
               valid, q, busy, overrun, valid_m, q_m);
    end
  endtask

  task automatic test_reset();
    clear = 1'b1;
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    clear = 1'b0;
    q_m = 4'b0000;
    valid_m = 1'b0;
    checks++;
    if ({q, valid, busy, frame_err, parity_err, overrun} !== 9'b0) begin
      errors++;
      $display("FAIL reset_state: q=%b valid=%b busy=%b flags=%b%b%b required all 0",
               q, valid, busy, frame_err, parity_err, overrun);
    end
  endtask

  task automatic test_basic();
    // A tick with the line high must not start a frame.
    cyc(1'b1, 1'b1, 1'b0);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_high_tick: busy=%b required 0", busy);
    end
    send_frame(4'b1011, 1'b0, 1'b1, 1, 1'b0);
    checks++;
    if (q !== 4'b1011 || valid !== 1'b1) begin
      errors++;
      $display("FAIL basic_word: q=%b valid=%b required q=1011 valid=1", q, valid);
    end
  endtask

  task automatic test_overrun();
    send_frame(4'b0110, 1'b0, 1'b1, 1, 1'b0);
    checks++;
    if (q !== 4'b1011) begin
      errors++;
      $display("FAIL overrun_keep: q=%b required 1011", q);
    end
    handshake(1'b1, 1'b0);
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL overrun_drain: valid=%b required 0", valid);
    end
  endtask

  task automatic test_simultaneous();
    send_frame(4'b1011, 1'b0, 1'b1, 1, 1'b0);
    send_frame(4'b0110, 1'b0, 1'b1, 1, 1'b1);
    checks++;
    if (q !== 4'b0110 || valid !== 1'b1 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL simultaneous: q=%b valid=%b ov=%b required 0110 1 0", q, valid,
               overrun);
    end
    handshake(1'b1, 1'b0);
  endtask

  task automatic test_frame_err();
    send_frame(4'b1100, 1'b0, 1'b0, 2, 1'b0);
    checks++;
    if (valid !== 1'b0 || q !== 4'b0110) begin
      errors++;
      $display("FAIL frame_err_word: valid=%b q=%b required 0 0110", valid, q);
    end
    // Parity mismatch together with a bad stop bit reports only the framing error.
    send_frame(4'b0011, 1'b1, 1'b0, 1, 1'b0);
  endtask

  task automatic test_sparse();
    send_frame(4'b1001, ParOn, 1'b1, 4, 1'b0);
    checks++;
    if (ParOn ? (valid !== 1'b0) : (q !== 4'b1001 || valid !== 1'b1)) begin
      errors++;
      $display("FAIL sparse: q=%b valid=%b", q, valid);
    end
    handshake(1'b1, 1'b0);
  endtask

  task automatic test_clear_midframe();
    send_frame(4'b0101, 1'b0, 1'b1, 1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    clear = 1'b1;
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    clear = 1'b0;
    q_m = 4'b0000;
    valid_m = 1'b0;
    checks++;
    if ({q, valid, busy, frame_err, parity_err, overrun} !== 9'b0) begin
      errors++;
      $display("FAIL clear_midframe: q=%b valid=%b busy=%b flags=%b%b%b required all 0",
               q, valid, busy, frame_err, parity_err, overrun);
    end
    cyc(1'b0, 1'b1, 1'b0);
    checks++;
    if ({valid, busy, frame_err, parity_err, overrun} !== 5'b0) begin
      errors++;
      $display("FAIL clear_after: valid=%b busy=%b flags=%b%b%b required all 0",
               valid, busy, frame_err, parity_err, overrun);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      send_frame(4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 4) != 0), $urandom_range(1, 3),
                 1'($urandom_range(0, 1)));
      for (int k = $urandom_range(0, 2); k > 0; k--) begin
        handshake(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
    end
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    clear   = 1'b1;
    tick    = 1'b0;
    d       = 1'b1;
    ready   = 1'b0;
    q_m     = 4'b0000;
    valid_m = 1'b0;
    test_reset();
    test_basic();
    test_overrun();
    test_simultaneous();
    test_frame_err();
    test_sparse();
    test_clear_midframe();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
